pport_host: RTL and testbench

- Initiator (host) end of the parallel-port byte interface served by the FPGA-side pport peripheral; performs the role the Raspberry Pi plays.
- Turns single-cycle write/read requests into pp_dir/pp_clk/data bus transactions and completes each on the peripheral's clock-feedback echo.
- Used for FPGA-to-FPGA bridging and as a synthesizable bench driver for pport-based designs (echo/line tests).

---
 rtl/pport_host_if.sv | 31 +++
 rtl/pport_host.sv | 112 +++++++++++
 tb/tb_pport_host.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pport_host_if.sv
// Request and parallel-port bus signals of the pport host, grouped so the
// host core and its environment share one bundle.
interface pport_host_if;
  logic       i_wr_stb;
  logic [7:0] i_wr_data;
  logic       i_rd_stb;
  logic       o_busy;
  logic       o_rd_stb;
  logic [7:0] o_rd_data;
  logic       o_err;
  logic       i_err_clr;
  logic       o_pp_dir;
  logic       o_pp_clk;
  logic [7:0] o_pp_data;
  logic       o_pp_oe;
  logic [7:0] i_pp_data;
  logic       i_pp_clkfb;

  // master: the host core; slave: requester plus peripheral side.
  modport master (
    input  i_wr_stb, i_wr_data, i_rd_stb, i_err_clr, i_pp_data, i_pp_clkfb,
    output o_busy, o_rd_stb, o_rd_data, o_err,
    output o_pp_dir, o_pp_clk, o_pp_data, o_pp_oe
  );

  modport slave (
    output i_wr_stb, i_wr_data, i_rd_stb, i_err_clr, i_pp_data, i_pp_clkfb,
    input  o_busy, o_rd_stb, o_rd_data, o_err,
    input  o_pp_dir, o_pp_clk, o_pp_data, o_pp_oe
  );
endinterface

// File: rtl/pport_host.sv
// Host end of the pport byte interface: turns single-cycle write/read requests
// into pp_dir/pp_clk bus transactions completed by the peripheral's clock echo.
module pport_host #(
  parameter int SETUP_CYCLES = 2,
  parameter int TURN_CYCLES  = 4,
  parameter int TIMEOUT      = 1024
) (
  input logic          i_clk,
  input logic          i_reset_n,
  pport_host_if.master pp
);

  localparam int MAX_ST = (TURN_CYCLES > SETUP_CYCLES) ? TURN_CYCLES : SETUP_CYCLES;
  localparam int CNT_MAX = (TIMEOUT > MAX_ST) ? TIMEOUT : MAX_ST;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, TURN, SETUP, WAITFB} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rd_q;
  logic          fb_q, fb_s;
  logic [7:0]    data_q, data_s;

  assign pp.o_busy = (state != IDLE);

  // NOTE: every register here uses <= so all of them sample the pre-edge
  // values of each other; a blocking = would leak a new value into the same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_q         <= 1'b0;
      fb_q         <= 1'b0;
      fb_s         <= 1'b0;
      data_q       <= '0;
      data_s       <= '0;
      pp.o_pp_dir  <= 1'b1;
      pp.o_pp_oe   <= 1'b0;
      pp.o_pp_clk  <= 1'b0;
      pp.o_pp_data <= '0;
      pp.o_rd_stb  <= 1'b0;
      pp.o_rd_data <= '0;
      pp.o_err     <= 1'b0;
    end else begin
      // Echo and data share one synchronizer depth so they stay aligned.
      fb_q        <= pp.i_pp_clkfb;
      fb_s        <= fb_q;
      data_q      <= pp.i_pp_data;
      data_s      <= data_q;
      pp.o_rd_stb <= 1'b0;
      if (pp.i_err_clr) pp.o_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pp.i_wr_stb || pp.i_rd_stb) begin
            rd_q <= !pp.i_wr_stb;
            cnt  <= '0;
            if (pp.i_wr_stb) pp.o_pp_data <= pp.i_wr_data;
            if (pp.i_wr_stb != pp.o_pp_dir) begin
              pp.o_pp_dir <= pp.i_wr_stb;
              pp.o_pp_oe  <= 1'b0;
              state       <= TURN;
            end else begin
              pp.o_pp_oe <= pp.o_pp_dir;
              state      <= SETUP;
            end
          end
        end

        TURN: begin
          if (cnt == CW'(TURN_CYCLES - 1)) begin
            pp.o_pp_oe <= pp.o_pp_dir;
            cnt        <= '0;
            state      <= SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SETUP: begin
          if (cnt == CW'(SETUP_CYCLES - 1)) begin
            pp.o_pp_clk <= ~pp.o_pp_clk;
            cnt         <= '0;
            state       <= WAITFB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAITFB: begin
          if (fb_s == pp.o_pp_clk) begin
            state <= IDLE;
            if (rd_q) begin
              pp.o_rd_data <= data_s;
              pp.o_rd_stb  <= 1'b1;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Abort leaves o_pp_clk toggled; the next byte toggles from here.
            pp.o_err <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pport_host.sv
// Self-checking bench for pport_host: a registered-echo peripheral model plus a
// transaction-level timing model predicting toggle, completion and read data.
module tb_pport_host;
  localparam int S  = 2;
  localparam int T  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pport_host_if bus ();

  pport_host #(.SETUP_CYCLES(S), .TURN_CYCLES(T), .TIMEOUT(TO)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .pp       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Peripheral model: echoes pp_clk one cycle late and logs every written byte.
  logic       echo_en = 1'b1;
  logic [7:0] periph_byte = 8'h00;
  logic       fb, last_clk;
  logic [7:0] cap_q[$];

  assign bus.i_pp_clkfb = fb;
  assign bus.i_pp_data  = periph_byte;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb       <= 1'b0;
      last_clk <= 1'b0;
    end else begin
      if (echo_en) fb <= bus.o_pp_clk;
      if (bus.o_pp_clk != last_clk) begin
        last_clk <= bus.o_pp_clk;
        if (bus.o_pp_dir) cap_q.push_back(bus.o_pp_data);
      end
    end
  end

  // Reference state of the bus as seen from outside.
  logic       m_dir  = 1'b1;
  logic       m_clk  = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_err  = 1'b0;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   bus.o_busy,    0);
    check({tag, "_dir"},    bus.o_pp_dir,  1);
    check({tag, "_oe"},     bus.o_pp_oe,   0);
    check({tag, "_ppclk"},  bus.o_pp_clk,  0);
    check({tag, "_ppdata"}, bus.o_pp_data, 0);
    check({tag, "_rdstb"},  bus.o_rd_stb,  0);
    check({tag, "_rddata"}, bus.o_rd_data, 0);
    check({tag, "_err"},    bus.o_err,     0);
  endtask

  // One complete transaction. both: raise both strobes at accept;
  // noise: fire both strobes again while busy, which must be ignored.
  task automatic run_txn(input bit is_rd, input logic [7:0] d, input bit both,
                         input bit noise, input string tag);
    bit         turn, tmo, exp_oe;
    int         toggle_exp, done_exp, k, toggle_k, bus_bad, rd_pulses;
    logic [7:0] rd_val, got;
    logic       start_clk, eff_rd;

    eff_rd     = is_rd && !both;
    turn       = (!eff_rd) != m_dir;
    tmo        = !echo_en;
    toggle_exp = (turn ? T : 0) + S;
    done_exp   = toggle_exp + (tmo ? TO : 4);

    @(negedge clk);
    check({tag, "_idle"}, bus.o_busy, 0);
    start_clk         = bus.o_pp_clk;
    bus.i_wr_stb      = !is_rd || both;
    bus.i_rd_stb      = is_rd || both;
    bus.i_wr_data     = d;
    @(posedge clk);
    #1;
    bus.i_wr_stb  = 1'b0;
    bus.i_rd_stb  = 1'b0;
    bus.i_wr_data = 8'($urandom);
    if (!eff_rd) m_data = d;
    m_dir = !eff_rd;
    m_clk = ~m_clk;

    k = 0; toggle_k = -1; bus_bad = 0; rd_pulses = 0; rd_val = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.o_pp_clk !== start_clk && toggle_k < 0) toggle_k = k;
      exp_oe = m_dir && !(turn && k < T);
      if (bus.o_pp_oe !== exp_oe || bus.o_pp_dir !== m_dir || bus.o_pp_data !== m_data)
        bus_bad++;
      if (bus.o_rd_stb) begin
        rd_pulses++;
        rd_val = bus.o_rd_data;
      end
      if (!bus.o_busy) break;
      if (k > done_exp + 8) break;
      if (noise && k == 1) begin
        bus.i_wr_stb  = 1'b1;
        bus.i_rd_stb  = 1'b1;
        bus.i_wr_data = ~m_data;
      end
      @(posedge clk);
      #1;
      bus.i_wr_stb = 1'b0;
      bus.i_rd_stb = 1'b0;
      k++;
    end
    @(negedge clk);
    if (bus.o_rd_stb) rd_pulses++;
    check({tag, "_quiet"}, bus.o_busy, 0);

    m_err = m_err | tmo;
    check({tag, "_done"},   k,           done_exp);
    check({tag, "_toggle"}, toggle_k,    toggle_exp);
    check({tag, "_ppclk"},  bus.o_pp_clk, m_clk);
    check({tag, "_bus"},    bus_bad,     0);
    check({tag, "_rdpuls"}, rd_pulses,   (eff_rd && !tmo) ? 1 : 0);
    check({tag, "_err"},    bus.o_err,   m_err);
    if (eff_rd && !tmo) check({tag, "_rddata"}, rd_val, periph_byte);
    if (!eff_rd) begin
      got = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
      check({tag, "_cap"}, got, d);
    end
    check({tag, "_capq"}, cap_q.size(), 0);
  endtask

  task automatic recover_from_timeout(input bit clear_err);
    echo_en = 1'b1;
    if (clear_err) begin
      @(negedge clk);
      bus.i_err_clr = 1'b1;
      @(negedge clk);
      bus.i_err_clr = 1'b0;
      m_err = 1'b0;
      check("err_clr", bus.o_err, 0);
    end
    repeat (4) @(negedge clk);
  endtask

  int rd_seen;

  initial begin
    bus.i_wr_stb  = 1'b0;
    bus.i_rd_stb  = 1'b0;
    bus.i_wr_data = 8'h00;
    bus.i_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    run_txn(0, 8'hA5, 0, 0, "wr_a5");
    run_txn(0, 8'h48, 0, 0, "wr_48");
    run_txn(0, 8'h69, 0, 0, "wr_69");
    run_txn(0, 8'h0A, 0, 0, "wr_0a");

    periph_byte = 8'h3C;
    run_txn(1, 8'h00, 0, 0, "rd_3c");
    run_txn(0, 8'h5A, 0, 0, "wr_turn");

    echo_en = 1'b0;
    run_txn(0, 8'hC3, 0, 0, "wr_tmo");
    recover_from_timeout(1);
    run_txn(0, 8'h77, 0, 0, "wr_after_tmo");

    run_txn(1, 8'h11, 1, 1, "both_stb");

    // Asynchronous reset in the middle of a read's WAITFB.
    periph_byte = 8'h9E;
    @(negedge clk);
    bus.i_rd_stb = 1'b1;
    @(posedge clk);
    #1 bus.i_rd_stb = 1'b0;
    repeat (T + S + 1) @(posedge clk);
    @(negedge clk);
    check("mid_busy", bus.o_busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    m_dir = 1'b1; m_clk = 1'b0; m_data = 8'h00; m_err = 1'b0;
    cap_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rd_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_rd_stb) rd_seen++;
    end
    check("rst_no_rdstb", rd_seen, 0);

    for (int i = 0; i < 30; i++) begin
      bit rd;
      bit off;
      rd          = 1'($urandom);
      off         = ($urandom_range(0, 7) == 0);
      periph_byte = 8'($urandom);
      echo_en     = !off;
      run_txn(rd, 8'($urandom), 0, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
      if (off) recover_from_timeout(1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
